cpu_mmu: RTL and testbench

Multi-cycle, non-pipelined 32-bit MIPS-I-subset CPU with a fixed-mapping MMU. It fetches, decodes and executes one instruction at a time. Every instruction and data virtual address passes through a segment translator before reaching a single shared data bus that connects to memory or I/O. It is the top-level processing element of the system, sitting directly on the memory/IO bus.

---
 rtl/cpu_mmu.sv | 185 ++++++++++++++++++
 tb/tb_cpu_mmu.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_mmu.sv
// Multi-cycle MIPS-I subset CPU (FETCH/EXEC/MEM/WB) whose instruction and data
// requests pass through a fixed-segment MMU onto one shared memory/IO bus.
module cpu_mmu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        res,
  input  logic        ready,
  input  logic        db_ready,
  input  logic [31:0] db_dataIn,
  output logic [31:0] db_dataOut,
  output logic [31:0] db_addr,
  output logic [1:0]  db_accessType,
  output logic        db_io,
  output logic [31:0] vAddr
);
  localparam logic [1:0] ACC_NONE = 2'd0;
  localparam logic [1:0] ACC_R    = 2'd1;
  localparam logic [1:0] ACC_W    = 2'd2;
  localparam logic [1:0] ACC_X    = 2'd3;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_MEM   = 2'd2,
    S_WB    = 2'd3
  } state_e;

  state_e      state_q;
  logic [31:0] pc_q, npc_q, ir_q;
  logic [4:0]  ld_dst_q;
  logic [31:0] gpr_q [32];

  // Returns {io, physical address}.
  function automatic logic [32:0] mmu_xlate(input logic [31:0] va);
    logic [32:0] r;
    if (va[31:28] == 4'hF)       r = {1'b1, 4'h0, va[27:0]};
    else if (va[31:30] == 2'b10) r = {1'b0, va & 32'h1FFF_FFFF};
    else                         r = {1'b0, va};
    return r;
  endfunction

  // Execute-stage decode; the fetched word is on db_dataIn during EXEC.
  logic [5:0]         ex_op, ex_fn;
  logic [4:0]         ex_rs, ex_rt, ex_rd, ex_sh;
  logic [15:0]        ex_imm;
  logic [25:0]        ex_idx;
  logic [31:0]        rs_v, rt_v, simm, zimm, pc4, br_tgt, j_tgt;
  logic signed [31:0] rs_s, rt_s, simm_s;

  assign ex_op  = db_dataIn[31:26];
  assign ex_rs  = db_dataIn[25:21];
  assign ex_rt  = db_dataIn[20:16];
  assign ex_rd  = db_dataIn[15:11];
  assign ex_sh  = db_dataIn[10:6];
  assign ex_fn  = db_dataIn[5:0];
  assign ex_imm = db_dataIn[15:0];
  assign ex_idx = db_dataIn[25:0];

  assign rs_v   = gpr_q[ex_rs];
  assign rt_v   = gpr_q[ex_rt];
  assign rs_s   = $signed(rs_v);
  assign rt_s   = $signed(rt_v);
  assign simm   = {{16{ex_imm[15]}}, ex_imm};
  assign simm_s = $signed(simm);
  assign zimm   = {16'h0000, ex_imm};
  assign pc4    = pc_q + 32'd4;
  assign br_tgt = pc4 + {simm[29:0], 2'b00};
  assign j_tgt  = {pc4[31:28], ex_idx, 2'b00};

  logic        ex_wr, ex_mem;
  logic [4:0]  ex_wdst;
  logic [31:0] ex_wval, ex_nxt;

  always_comb begin
    ex_wr   = 1'b0;
    ex_wdst = ex_rd;
    ex_wval = '0;
    ex_nxt  = npc_q + 32'd4;
    ex_mem  = 1'b0;
    case (ex_op)
      6'h00: begin
        ex_wr = 1'b1;
        case (ex_fn)
          6'h00: ex_wval = rt_v << ex_sh;
          6'h02: ex_wval = rt_v >> ex_sh;
          6'h03: ex_wval = rt_s >>> ex_sh;
          6'h08: begin ex_wr = 1'b0; ex_nxt = rs_v; end
          6'h09: begin ex_nxt = rs_v; ex_wval = pc_q + 32'd8; end
          6'h21: ex_wval = rs_v + rt_v;
          6'h23: ex_wval = rs_v - rt_v;
          6'h24: ex_wval = rs_v & rt_v;
          6'h25: ex_wval = rs_v | rt_v;
          6'h26: ex_wval = rs_v ^ rt_v;
          6'h27: ex_wval = ~(rs_v | rt_v);
          6'h2A: ex_wval = {31'd0, (rs_s < rt_s)};
          6'h2B: ex_wval = {31'd0, (rs_v < rt_v)};
          default: ex_wr = 1'b0;
        endcase
      end
      6'h02: ex_nxt = j_tgt;
      6'h03: begin ex_nxt = j_tgt; ex_wr = 1'b1; ex_wdst = 5'd31; ex_wval = pc_q + 32'd8; end
      6'h04: if (rs_v == rt_v) ex_nxt = br_tgt;
      6'h05: if (rs_v != rt_v) ex_nxt = br_tgt;
      6'h09: begin ex_wr = 1'b1; ex_wdst = ex_rt; ex_wval = rs_v + simm; end
      6'h0A: begin ex_wr = 1'b1; ex_wdst = ex_rt; ex_wval = {31'd0, (rs_s < simm_s)}; end
      6'h0B: begin ex_wr = 1'b1; ex_wdst = ex_rt; ex_wval = {31'd0, (rs_v < simm)}; end
      6'h0C: begin ex_wr = 1'b1; ex_wdst = ex_rt; ex_wval = rs_v & zimm; end
      6'h0D: begin ex_wr = 1'b1; ex_wdst = ex_rt; ex_wval = rs_v | zimm; end
      6'h0E: begin ex_wr = 1'b1; ex_wdst = ex_rt; ex_wval = rs_v ^ zimm; end
      6'h0F: begin ex_wr = 1'b1; ex_wdst = ex_rt; ex_wval = {ex_imm, 16'h0000}; end
      6'h23, 6'h2B: ex_mem = 1'b1;
      default: ;
    endcase
  end

  // Memory-stage address and store data come from the latched load/store word.
  logic [31:0] m_va;
  logic        m_store;

  assign m_va    = gpr_q[ir_q[25:21]] + {{16{ir_q[15]}}, ir_q[15:0]};
  assign m_store = (ir_q[31:26] == 6'h2B);

  logic [1:0]  req_acc;
  logic [31:0] req_va, req_wd;
  logic [32:0] xl;

  always_comb begin
    req_acc = ACC_NONE;
    req_va  = '0;
    req_wd  = '0;
    case (state_q)
      S_FETCH: begin req_acc = ACC_X; req_va = pc_q; end
      S_MEM: begin
        req_acc = m_store ? ACC_W : ACC_R;
        req_va  = m_va;
        req_wd  = m_store ? gpr_q[ir_q[20:16]] : '0;
      end
      default: ;
    endcase
    xl            = mmu_xlate(req_va);
    db_accessType = ACC_NONE;
    db_io         = 1'b0;
    db_addr       = '0;
    db_dataOut    = '0;
    vAddr         = '0;
    if (!res) begin
      db_accessType = ready ? req_acc : ACC_NONE;
      db_io         = xl[32] && (req_acc != ACC_NONE);
      db_addr       = xl[31:0];
      db_dataOut    = req_wd;
      vAddr         = req_va;
    end
  end

  always_ff @(posedge clk) begin
    if (res) begin
      state_q  <= S_FETCH;
      pc_q     <= RESET_PC;
      npc_q    <= RESET_PC + 32'd4;
      ir_q     <= '0;
      ld_dst_q <= '0;
      for (int i = 0; i < 32; i++) gpr_q[i] <= '0;
    end else if (ready) begin
      case (state_q)
        S_FETCH: if (db_ready) state_q <= S_EXEC;
        S_EXEC: begin
          ir_q     <= db_dataIn;
          ld_dst_q <= ex_rt;
          pc_q     <= npc_q;
          npc_q    <= ex_nxt;
          if (ex_wr && ex_wdst != 5'd0) gpr_q[ex_wdst] <= ex_wval;
          state_q  <= ex_mem ? S_MEM : S_FETCH;
        end
        S_MEM: if (db_ready) state_q <= m_store ? S_FETCH : S_WB;
        S_WB: begin
          if (ld_dst_q != 5'd0) gpr_q[ld_dst_q] <= db_dataIn;
          state_q <= S_FETCH;
        end
        default: state_q <= S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_mmu.sv
// Directed bench for cpu_mmu: a small bus-side memory serves fetches and data,
// and each bus request is compared against hand-computed addresses and data.
module tb_cpu_mmu;
  localparam logic [1:0] ACC_NONE = 2'd0;
  localparam logic [1:0] ACC_R    = 2'd1;
  localparam logic [1:0] ACC_W    = 2'd2;
  localparam logic [1:0] ACC_X    = 2'd3;

  logic        clk, res, ready, db_ready;
  logic [31:0] db_dataIn, db_dataOut, db_addr, vAddr;
  logic [1:0]  db_accessType;
  logic        db_io;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [4096];
  logic [31:0] alu_ins [15];
  logic [31:0] alu_exp [15];

  cpu_mmu #(.RESET_PC(32'h8000_0000)) dut (
    .clk(clk), .res(res), .ready(ready), .db_ready(db_ready),
    .db_dataIn(db_dataIn), .db_dataOut(db_dataOut), .db_addr(db_addr),
    .db_accessType(db_accessType), .db_io(db_io), .vAddr(vAddr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  function automatic logic [31:0] rtype(input logic [4:0] rs, rt, rd, sh, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction
  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs, rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction
  function automatic logic [31:0] jtype(input logic [5:0] op, input logic [25:0] idx);
    return {op, idx};
  endfunction

  task automatic put(input logic [31:0] a, input logic [31:0] w);
    mem[a[13:2]] = w;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: sample the request before the edge, then play the memory side.
  task automatic tick();
    logic [1:0]  acc;
    logic [31:0] a, d;
    logic        io, go;
    @(negedge clk);
    acc = db_accessType;
    a   = db_addr;
    d   = db_dataOut;
    io  = db_io;
    go  = ready && db_ready && !res;
    @(posedge clk);
    #1;
    if (go) begin
      if (acc == ACC_X || acc == ACC_R) db_dataIn = io ? 32'h0 : mem[a[13:2]];
      else if (acc == ACC_W && !io) mem[a[13:2]] = d;
    end
    #1;
  endtask

  task automatic wait_req(input string tag, input logic [1:0] acc, input int maxt,
                          input logic [31:0] va, input logic [31:0] pa, input logic io);
    int n = 0;
    while (db_accessType !== acc && n < maxt) begin
      tick();
      n++;
    end
    chk({tag, "/acc"}, 32'(db_accessType), 32'(acc));
    chk({tag, "/vaddr"}, vAddr, va);
    chk({tag, "/addr"}, db_addr, pa);
    chk({tag, "/io"}, 32'(db_io), 32'(io));
  endtask

  task automatic fetch(input string tag, input logic [31:0] va, input int maxt);
    wait_req(tag, ACC_X, maxt, va, va & 32'h1FFF_FFFF, 1'b0);
    tick();
  endtask

  initial begin
    res = 1'b1; ready = 1'b1; db_ready = 1'b1; db_dataIn = '0;
    for (int i = 0; i < 4096; i++) mem[i] = '0;

    put(32'h00, 32'h0);
    put(32'h04, itype(6'h0F, 5'd0, 5'd1, 16'hF000));
    put(32'h08, itype(6'h0D, 5'd0, 5'd2, 16'h0041));
    put(32'h0C, itype(6'h2B, 5'd1, 5'd2, 16'h0001));
    put(32'h10, itype(6'h0F, 5'd0, 5'd3, 16'h1234));
    put(32'h14, itype(6'h0D, 5'd3, 5'd3, 16'h5678));
    put(32'h18, itype(6'h0F, 5'd0, 5'd4, 16'h8000));
    put(32'h1C, itype(6'h2B, 5'd4, 5'd3, 16'h1000));
    put(32'h20, itype(6'h0F, 5'd0, 5'd5, 16'hA000));
    put(32'h24, itype(6'h23, 5'd5, 5'd6, 16'h1000));
    put(32'h28, itype(6'h2B, 5'd0, 5'd6, 16'h2000));
    put(32'h2C, itype(6'h09, 5'd0, 5'd7, 16'h0035));
    put(32'h30, itype(6'h04, 5'd7, 5'd7, 16'h0003));
    put(32'h34, itype(6'h09, 5'd0, 5'd8, 16'h0009));
    put(32'h38, itype(6'h09, 5'd0, 5'd8, 16'h0077));
    put(32'h3C, itype(6'h09, 5'd0, 5'd8, 16'h0066));
    put(32'h40, itype(6'h05, 5'd7, 5'd7, 16'h0005));
    put(32'h44, 32'h0);
    put(32'h48, itype(6'h2B, 5'd0, 5'd8, 16'h2004));
    put(32'h4C, itype(6'h09, 5'd0, 5'd9, 16'hFFF0));

    // $9 = 0xFFFFFFF0, $7 = 0x35
    alu_ins[0]  = rtype(5'd9, 5'd7, 5'd10, 5'd0, 6'h21); alu_exp[0]  = 32'h0000_0025;
    alu_ins[1]  = rtype(5'd7, 5'd9, 5'd10, 5'd0, 6'h23); alu_exp[1]  = 32'h0000_0045;
    alu_ins[2]  = rtype(5'd9, 5'd7, 5'd10, 5'd0, 6'h24); alu_exp[2]  = 32'h0000_0030;
    alu_ins[3]  = rtype(5'd9, 5'd7, 5'd10, 5'd0, 6'h25); alu_exp[3]  = 32'hFFFF_FFF5;
    alu_ins[4]  = rtype(5'd9, 5'd7, 5'd10, 5'd0, 6'h26); alu_exp[4]  = 32'hFFFF_FFC5;
    alu_ins[5]  = rtype(5'd9, 5'd7, 5'd10, 5'd0, 6'h27); alu_exp[5]  = 32'h0000_000A;
    alu_ins[6]  = rtype(5'd9, 5'd7, 5'd10, 5'd0, 6'h2A); alu_exp[6]  = 32'h0000_0001;
    alu_ins[7]  = rtype(5'd9, 5'd7, 5'd10, 5'd0, 6'h2B); alu_exp[7]  = 32'h0000_0000;
    alu_ins[8]  = rtype(5'd0, 5'd9, 5'd10, 5'd4, 6'h00); alu_exp[8]  = 32'hFFFF_FF00;
    alu_ins[9]  = rtype(5'd0, 5'd9, 5'd10, 5'd4, 6'h02); alu_exp[9]  = 32'h0FFF_FFFF;
    alu_ins[10] = rtype(5'd0, 5'd9, 5'd10, 5'd4, 6'h03); alu_exp[10] = 32'hFFFF_FFFF;
    alu_ins[11] = itype(6'h0A, 5'd9, 5'd10, 16'hFFFF);   alu_exp[11] = 32'h0000_0001;
    alu_ins[12] = itype(6'h0B, 5'd7, 5'd10, 16'hFFFF);   alu_exp[12] = 32'h0000_0001;
    alu_ins[13] = itype(6'h0C, 5'd9, 5'd10, 16'hFF0F);   alu_exp[13] = 32'h0000_FF00;
    alu_ins[14] = itype(6'h0E, 5'd9, 5'd10, 16'h8001);   alu_exp[14] = 32'hFFFF_7FF1;
    for (int k = 0; k < 15; k++) begin
      put(32'h50 + 32'(8 * k), alu_ins[k]);
      put(32'h54 + 32'(8 * k), itype(6'h2B, 5'd0, 5'd10, 16'h2010));
    end

    put(32'hC8,  jtype(6'h02, 26'h40));
    put(32'hCC,  32'h0);
    put(32'h100, jtype(6'h03, 26'h80));
    put(32'h104, 32'h0);
    put(32'h108, itype(6'h2B, 5'd0, 5'd31, 16'h2008));
    put(32'h10C, jtype(6'h02, 26'hC0));
    put(32'h110, 32'h0);
    put(32'h200, rtype(5'd31, 5'd0, 5'd0, 5'd0, 6'h08));
    put(32'h204, 32'h0);
    put(32'h300, jtype(6'h02, 26'hC0));
    put(32'h304, 32'h0);

    repeat (2) tick();
    chk("rst/acc", 32'(db_accessType), 32'(ACC_NONE));
    chk("rst/io", 32'(db_io), 32'h0);
    chk("rst/addr", db_addr, 32'h0);
    chk("rst/dout", db_dataOut, 32'h0);
    chk("rst/vaddr", vAddr, 32'h0);

    res = 1'b0; db_ready = 1'b0;
    #1;
    wait_req("fetch0", ACC_X, 0, 32'h8000_0000, 32'h0000_0000, 1'b0);
    repeat (2) tick();
    wait_req("fetch0_hold", ACC_X, 0, 32'h8000_0000, 32'h0000_0000, 1'b0);
    db_ready = 1'b1;
    tick();
    chk("exec0/acc", 32'(db_accessType), 32'(ACC_NONE));
    chk("exec0/io", 32'(db_io), 32'h0);
    fetch("fetch4", 32'h8000_0004, 1);
    fetch("fetch8", 32'h8000_0008, 1);
    fetch("fetchC", 32'h8000_000C, 1);

    wait_req("sw_io", ACC_W, 1, 32'hF000_0001, 32'h0000_0001, 1'b1);
    chk("sw_io/data", db_dataOut, 32'h0000_0041);
    ready = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("hold%0d/acc", i), 32'(db_accessType), 32'(ACC_NONE));
      chk($sformatf("hold%0d/addr", i), db_addr, 32'h0000_0001);
      chk($sformatf("hold%0d/vaddr", i), vAddr, 32'hF000_0001);
      chk($sformatf("hold%0d/dout", i), db_dataOut, 32'h0000_0041);
      tick();
    end
    ready = 1'b1;
    #1;
    wait_req("sw_io_resume", ACC_W, 0, 32'hF000_0001, 32'h0000_0001, 1'b1);
    chk("sw_io_resume/data", db_dataOut, 32'h0000_0041);
    tick();

    fetch("fetch10", 32'h8000_0010, 0);
    fetch("fetch14", 32'h8000_0014, 1);
    fetch("fetch18", 32'h8000_0018, 1);
    fetch("fetch1C", 32'h8000_001C, 1);
    wait_req("sw_k0", ACC_W, 1, 32'h8000_1000, 32'h0000_1000, 1'b0);
    chk("sw_k0/data", db_dataOut, 32'h1234_5678);
    tick();
    fetch("fetch20", 32'h8000_0020, 0);
    fetch("fetch24", 32'h8000_0024, 1);
    wait_req("lw_k1", ACC_R, 1, 32'hA000_1000, 32'h0000_1000, 1'b0);
    tick();
    fetch("fetch28", 32'h8000_0028, 1);
    wait_req("sw_kuseg", ACC_W, 1, 32'h0000_2000, 32'h0000_2000, 1'b0);
    chk("sw_kuseg/data", db_dataOut, 32'h1234_5678);
    tick();

    fetch("fetch2C", 32'h8000_002C, 0);
    fetch("beq", 32'h8000_0030, 1);
    fetch("delay", 32'h8000_0034, 1);
    fetch("target", 32'h8000_0040, 1);
    fetch("bne_slot", 32'h8000_0044, 1);
    fetch("fallthru", 32'h8000_0048, 1);
    wait_req("sw_br", ACC_W, 1, 32'h0000_2004, 32'h0000_2004, 1'b0);
    chk("sw_br/data", db_dataOut, 32'h0000_0009);
    tick();

    fetch("fetch4C", 32'h8000_004C, 0);
    for (int k = 0; k < 15; k++) begin
      wait_req($sformatf("alu%0d", k), ACC_W, 6, 32'h0000_2010, 32'h0000_2010, 1'b0);
      chk($sformatf("alu%0d/data", k), db_dataOut, alu_exp[k]);
      tick();
    end

    fetch("j", 32'h8000_00C8, 0);
    fetch("j_slot", 32'h8000_00CC, 1);
    fetch("jal", 32'h8000_0100, 1);
    fetch("jal_slot", 32'h8000_0104, 1);
    fetch("jr", 32'h8000_0200, 1);
    fetch("jr_slot", 32'h8000_0204, 1);
    fetch("ret", 32'h8000_0108, 1);
    wait_req("sw_ra", ACC_W, 1, 32'h0000_2008, 32'h0000_2008, 1'b0);
    chk("sw_ra/data", db_dataOut, 32'h8000_0108);
    tick();

    repeat (3) tick();
    res = 1'b1;
    tick();
    chk("rst2/acc", 32'(db_accessType), 32'(ACC_NONE));
    chk("rst2/vaddr", vAddr, 32'h0);
    res = 1'b0;
    #1;
    wait_req("rst2_fetch", ACC_X, 0, 32'h8000_0000, 32'h0000_0000, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
